// File: rtl/aidc_zvc_comp.sv
// Zero-value compressor: folds a block of W-channel beats into an occupancy bitmap plus
// the nonzero words packed low, one record per block through a single output register.
module aidc_zvc_comp #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned BLK_BEATS = 4,
    localparam int unsigned NWORDS   = BLK_BEATS * DATA_W / WORD_W,
    localparam int unsigned CNT_W    = $clog2(NWORDS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     wlast_i,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    output logic                     comp_valid_o,
    input  logic                     comp_ready_i,
    output logic [NWORDS-1:0]        comp_bitmap_o,
    output logic [CNT_W-1:0]         comp_cnt_o,
    output logic [NWORDS*WORD_W-1:0] comp_data_o,
    output logic                     comp_fail_o,
    output logic                     comp_err_o
);

    localparam int unsigned WPB    = DATA_W / WORD_W;
    localparam int unsigned BCNT_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;

    typedef enum logic {StAcc, StHold} state_e;

    state_e                    state_q, state_d;
    logic                      wready_q, wready_d;
    logic [BCNT_W-1:0]         bcnt_q, bcnt_d;
    logic [NWORDS-1:0]         bitmap_q, bitmap_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NWORDS*WORD_W-1:0]  data_q, data_d;
    logic                      err_q, err_d;

    logic                      out_valid_q, out_valid_d;
    logic [NWORDS-1:0]         out_bitmap_q, out_bitmap_d;
    logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
    logic [NWORDS*WORD_W-1:0]  out_data_q, out_data_d;
    logic                      out_fail_q, out_fail_d;
    logic                      out_err_q, out_err_d;

    logic                      beat_fire, at_end, blk_done, slot_free, beat_err;
    logic [NWORDS-1:0]         nb_bitmap;
    logic [CNT_W-1:0]          nb_cnt;
    logic [NWORDS*WORD_W-1:0]  nb_data;

    assign beat_fire = wvalid_i & wready_q;
    assign at_end    = (bcnt_q == BCNT_W'(BLK_BEATS - 1));
    assign blk_done  = beat_fire & (wlast_i | at_end);
    assign beat_err  = wlast_i ^ at_end;
    assign slot_free = ~out_valid_q | comp_ready_i;

    // Accumulator contents after appending the current beat's nonzero words in index order.
    always_comb begin
        nb_bitmap = bitmap_q;
        nb_cnt    = cnt_q;
        nb_data   = data_q;
        for (int k = 0; k < WPB; k++) begin
            if (wdata_i[k*WORD_W +: WORD_W] != '0) begin
                nb_bitmap[int'(bcnt_q) * WPB + k]        = 1'b1;
                nb_data[int'(nb_cnt) * WORD_W +: WORD_W] = wdata_i[k*WORD_W +: WORD_W];
                nb_cnt                                   = nb_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        bitmap_d     = bitmap_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q & ~comp_ready_i;
        out_bitmap_d = out_bitmap_q;
        out_cnt_d    = out_cnt_q;
        out_data_d   = out_data_q;
        out_fail_d   = out_fail_q;
        out_err_d    = out_err_q;

        unique case (state_q)
            StAcc: begin
                if (blk_done && slot_free) begin
                    out_valid_d  = 1'b1;
                    out_bitmap_d = nb_bitmap;
                    out_cnt_d    = nb_cnt;
                    out_data_d   = nb_data;
                    out_fail_d   = (nb_cnt == CNT_W'(NWORDS));
                    out_err_d    = beat_err;
                    bcnt_d       = '0;
                    bitmap_d     = '0;
                    cnt_d        = '0;
                    data_d       = '0;
                    err_d        = 1'b0;
                end else if (blk_done) begin
                    // Park the finished record in the accumulator until the slot drains.
                    bitmap_d = nb_bitmap;
                    cnt_d    = nb_cnt;
                    data_d   = nb_data;
                    err_d    = beat_err;
                    bcnt_d   = '0;
                    state_d  = StHold;
                end else if (beat_fire) begin
                    bitmap_d = nb_bitmap;
                    cnt_d    = nb_cnt;
                    data_d   = nb_data;
                    bcnt_d   = bcnt_q + BCNT_W'(1);
                end
            end
            StHold: begin
                if (slot_free) begin
                    out_valid_d  = 1'b1;
                    out_bitmap_d = bitmap_q;
                    out_cnt_d    = cnt_q;
                    out_data_d   = data_q;
                    out_fail_d   = (cnt_q == CNT_W'(NWORDS));
                    out_err_d    = err_q;
                    bcnt_d       = '0;
                    bitmap_d     = '0;
                    cnt_d        = '0;
                    data_d       = '0;
                    err_d        = 1'b0;
                    state_d      = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase

        wready_d = (state_d == StAcc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAcc;
            wready_q     <= 1'b0;
            bcnt_q       <= '0;
            bitmap_q     <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bitmap_q <= '0;
            out_cnt_q    <= '0;
            out_data_q   <= '0;
            out_fail_q   <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wready_q     <= wready_d;
            bcnt_q       <= bcnt_d;
            bitmap_q     <= bitmap_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_bitmap_q <= out_bitmap_d;
            out_cnt_q    <= out_cnt_d;
            out_data_q   <= out_data_d;
            out_fail_q   <= out_fail_d;
            out_err_q    <= out_err_d;
        end
    end

    assign wready_o      = wready_q;
    assign comp_valid_o  = out_valid_q;
    assign comp_bitmap_o = out_bitmap_q;
    assign comp_cnt_o    = out_cnt_q;
    assign comp_data_o   = out_data_q;
    assign comp_fail_o   = out_fail_q;
    assign comp_err_o    = out_err_q;

endmodule

// File: tb/tb_aidc_zvc_comp.sv
// Directed bench for aidc_zvc_comp: table of hand-computed blocks plus backpressure and
// reset sequences.
module tb_aidc_zvc_comp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  wdata;
    logic         wlast, wvalid, wready;
    logic         comp_valid, comp_ready;
    logic [7:0]   comp_bitmap;
    logic [3:0]   comp_cnt;
    logic [255:0] comp_data;
    logic         comp_fail, comp_err;

    int errors = 0;
    int checks = 0;

    aidc_zvc_comp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wdata_i      (wdata),
        .wlast_i      (wlast),
        .wvalid_i     (wvalid),
        .wready_o     (wready),
        .comp_valid_o (comp_valid),
        .comp_ready_i (comp_ready),
        .comp_bitmap_o(comp_bitmap),
        .comp_cnt_o   (comp_cnt),
        .comp_data_o  (comp_data),
        .comp_fail_o  (comp_fail),
        .comp_err_o   (comp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] blk;   // word i at bits [32*i +: 32]
        int           nb;    // beats driven
        bit           last;  // WLAST on the final driven beat
        logic [7:0]   bm;
        logic [3:0]   cnt;
        logic [255:0] data;
        bit           fail;
        bit           err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_rec(input string tag, input int v);
        chk({tag, ".valid"},  256'(comp_valid),  256'(1));
        chk({tag, ".bitmap"}, 256'(comp_bitmap), 256'(vecs[v].bm));
        chk({tag, ".cnt"},    256'(comp_cnt),    256'(vecs[v].cnt));
        chk({tag, ".data"},   comp_data,         vecs[v].data);
        chk({tag, ".fail"},   256'(comp_fail),   256'(vecs[v].fail));
        chk({tag, ".err"},    256'(comp_err),    256'(vecs[v].err));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"},  256'(comp_valid),  256'(0));
        chk({tag, ".bitmap"}, 256'(comp_bitmap), 256'(0));
        chk({tag, ".cnt"},    256'(comp_cnt),    256'(0));
        chk({tag, ".data"},   comp_data,         256'(0));
        chk({tag, ".fail"},   256'(comp_fail),   256'(0));
        chk({tag, ".err"},    256'(comp_err),    256'(0));
        chk({tag, ".wready"}, 256'(wready),      256'(0));
    endtask

    // Drives one beat; called #1 after a rising edge, returns #1 after the accepting edge.
    task automatic drive_beat(input logic [63:0] d, input logic l);
        wvalid = 1'b1;
        wdata  = d;
        wlast  = l;
        chk("beat.wready", 256'(wready), 256'(1));
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
        wdata  = '0;
    endtask

    task automatic send_block(input int v, input bit do_check, input string tag);
        for (int b = 0; b < vecs[v].nb; b++) begin
            drive_beat(vecs[v].blk[64*b +: 64], (b == vecs[v].nb - 1) && vecs[v].last);
        end
        if (do_check) check_rec(tag, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{blk: '0, nb: 4, last: 1, bm: 8'h00, cnt: 4'd0, data: '0, fail: 0, err: 0};
        vecs[1] = '{blk: {32'hC, 32'hD, 32'h0, 32'hB, 32'h0, 32'h0, 32'hA, 32'h0},
                    nb: 4, last: 1, bm: 8'hD2, cnt: 4'd4,
                    data: {128'h0, 32'hC, 32'hD, 32'hB, 32'hA}, fail: 0, err: 0};
        vecs[2] = '{blk: {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                          32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    nb: 4, last: 1, bm: 8'hFF, cnt: 4'd8,
                    data: {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                           32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    fail: 1, err: 0};
        vecs[3] = '{blk: 256'h1, nb: 2, last: 1, bm: 8'h01, cnt: 4'd1,
                    data: 256'h1, fail: 0, err: 1};
        vecs[4] = '{blk: {32'h0, 32'h7, 32'h0, 32'h0, 32'h6, 32'h0, 32'h0, 32'h5},
                    nb: 4, last: 1, bm: 8'h49, cnt: 4'd3,
                    data: {160'h0, 32'h7, 32'h6, 32'h5}, fail: 0, err: 0};
        vecs[5] = '{blk: {32'hFFFFFFFF, 224'h0}, nb: 4, last: 0, bm: 8'h80, cnt: 4'd1,
                    data: 256'hFFFFFFFF, fail: 0, err: 1};
        vecs[6] = '{blk: 256'h00000022_00000011, nb: 1, last: 1, bm: 8'h03, cnt: 4'd2,
                    data: 256'h00000022_00000011, fail: 0, err: 1};

        rst_n      = 1'b0;
        wdata      = '0;
        wlast      = 1'b0;
        wvalid     = 1'b0;
        comp_ready = 1'b1;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset.wready", 256'(wready), 256'(1));
        chk("post_reset.valid", 256'(comp_valid), 256'(0));

        // Back-to-back blocks with the sink always ready.
        for (int v = 0; v < 7; v++) begin
            send_block(v, 1'b1, $sformatf("vec%0d", v));
        end
        @(posedge clk);
        #1;
        chk("drain.valid", 256'(comp_valid), 256'(0));

        // Backpressure: second block completes into a busy slot and parks in HOLD.
        comp_ready = 1'b0;
        send_block(1, 1'b1, "hold.first");
        send_block(2, 1'b0, "");
        chk("hold.wready", 256'(wready), 256'(0));
        check_rec("hold.enter", 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold.stable%0d.bitmap", i), 256'(comp_bitmap), 256'(8'hD2));
            chk($sformatf("hold.stable%0d.wready", i), 256'(wready), 256'(0));
        end
        chk("hold.stable.data", comp_data, vecs[1].data);
        comp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_rec("hold.second", 2);
        chk("hold.exit.wready", 256'(wready), 256'(1));
        @(posedge clk);
        #1;
        chk("hold.done.valid", 256'(comp_valid), 256'(0));

        // Reset while in HOLD.
        comp_ready = 1'b0;
        send_block(0, 1'b0, "");
        send_block(4, 1'b0, "");
        chk("rst_hold.wready_pre", 256'(wready), 256'(0));
        rst_n = 1'b0;
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst_n      = 1'b1;
        comp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold.wready_post", 256'(wready), 256'(1));

        // Reset mid-block: the partial block must not surface.
        drive_beat(64'h12345678_9ABCDEF0, 1'b0);
        drive_beat(64'h1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.valid", 256'(comp_valid), 256'(0));
        send_block(1, 1'b1, "after_rst");
        send_block(4, 1'b1, "after_rst2");
        @(posedge clk);
        #1;
        chk("final.valid", 256'(comp_valid), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
